note_judge: RTL and testbench
=============================

NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 SHALL have port CLOCK_50, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port current_number, input, 4 bits: step index from the speed-selectable step counter; legal values 0..10.
REQ-004 SHALL have port pattern, input, 11 bits: bit s set = note on step s; sampled at each step change.
REQ-005 SHALL have port key_press, input, 1 bit: raw player button, active-high, asynchronous to CLOCK_50.
REQ-006 SHALL have port score, output, 8 bits: accumulated points.
REQ-007 SHALL have port combo, output, 4 bits: consecutive hits.
REQ-008 SHALL have port lives, output, 2 bits: remaining lives.
REQ-009 SHALL have port note_active, output, 1 bit: high while a note awaits a hit.
REQ-010 SHALL have port hit, output, 1 bit: one-cycle pulse per judged hit.
REQ-011 SHALL have port miss, output, 1 bit: one-cycle pulse per judged miss.
REQ-012 SHALL have port game_over, output, 1 bit: high when lives reach 0.

Function
REQ-013 SHALL register current_number into prev_num every cycle; step_tick = (current_number != prev_num) and current_number <= 10.
REQ-014 SHALL pass key_press through a 2-flop synchroniser; press = synced high and previous synced low (single-cycle rising edge).
REQ-015 SHALL implement FSM states IDLE, ARMED, DONE, OVER; note_active = (state == ARMED).
REQ-016 On step_tick in IDLE or DONE: next state ARMED if pattern[current_number] = 1, else IDLE.
REQ-017 On step_tick in ARMED (note not hit): miss pulse, lives decrement, combo cleared, then next state per REQ-016 for the new step.
REQ-018 On press in ARMED without step_tick: hit pulse, combo increments saturating at 15, score adds 2 if combo (pre-increment) >= 8 else 1, saturating at 255; next state DONE.
REQ-019 Simultaneous step_tick and press in ARMED: press SHALL be judged as hit for the closing note (REQ-018 arithmetic), no miss; next state per REQ-016 for the new step.
REQ-020 Press in IDLE or DONE: miss pulse, combo cleared; lives per REQ-030.
REQ-021 At most one of hit/miss SHALL assert per cycle; hit takes precedence.
REQ-022 hit, miss, and all counter/state updates SHALL appear in the cycle after the triggering step_tick or press (latency 1 cycle; 3 cycles from key_press edge).
REQ-023 A decrement that makes lives 0 SHALL enter OVER in the same update; lives SHALL never wrap below 0.
REQ-024 In OVER: game_over = 1, score/combo/lives frozen, hit/miss held 0, step_tick and press ignored until reset.
REQ-025 current_number values 11..15 SHALL produce no step_tick and leave state unchanged.

Reset
REQ-026 On reset: state IDLE, score 0, combo 0, lives 3, hit 0, miss 0, note_active 0, game_over 0.
REQ-027 On reset: prev_num 4'd15, synchroniser and edge flops 0, so the first legal step after reset yields a step_tick.
REQ-028 Reset SHALL override any simultaneous step_tick or press, including mid-ARMED and in OVER.

Configuration
REQ-029 Macro NOTE_JUDGE_STRICT_PRESS_EN SHALL select the spurious-press penalty.
REQ-030 Defined: a press in IDLE or DONE also decrements lives (REQ-023 applies). Undefined: such a press only pulses miss and clears combo; lives unchanged.

Verification
REQ-031 Reset, pattern=11'h001, step 0 then 1, no press -> note_active 1 during step 0; miss pulse, lives 3->2, combo 0 after step 1.
REQ-032 Pattern all ones, press once per step for 10 steps -> 10 hit pulses, combo 10, score 1*8+2*2 = 12.
REQ-033 ARMED, press edge detected in the same cycle as step_tick -> hit pulse, no miss, lives unchanged, new step ARMED if its pattern bit is set.
REQ-034 Three unhit notes -> lives 3,2,1,0; game_over 1; further steps and presses leave score/lives unchanged and pulse nothing; reset -> lives 3, game_over 0.
REQ-035 Press in IDLE: with NOTE_JUDGE_STRICT_PRESS_EN lives 3->2 plus miss; without it lives stays 3, miss pulses, combo 0.

Source files
------------

// File: rtl/note_judge.sv
// note_judge: rhythm-game note judge that scores hits, counts misses and tracks lives.
// Build option: define NOTE_JUDGE_STRICT_PRESS_EN to make presses with no pending note cost a life.
module note_judge (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  current_number,
    input  logic [10:0] pattern,
    input  logic        key_press,
    output logic [7:0]  score,
    output logic [3:0]  combo,
    output logic [1:0]  lives,
    output logic        note_active,
    output logic        hit,
    output logic        miss,
    output logic        game_over
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE, OVER} state_t;

    state_t      state, state_next;
    logic [3:0]  prev_num;
    logic        sync1, sync2, sync3;
    logic        step_tick, press, note_bit;
    logic        hit_next, miss_next, lose;
    logic [7:0]  score_next;
    logic [3:0]  combo_next;
    logic [1:0]  lives_next;
    logic [8:0]  score_sum;
    logic [15:0] pattern_ext;

    assign pattern_ext = {5'd0, pattern};
    assign note_bit    = pattern_ext[current_number];
    assign step_tick   = (current_number != prev_num) && (current_number <= 4'd10);
    assign press       = sync2 && !sync3;

    // Step-change detector and two-flop key synchroniser with an edge-history flop
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prev_num <= 4'd15;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
        end else begin
            prev_num <= current_number;
            sync1    <= key_press;
            sync2    <= sync1;
            sync3    <= sync2;
        end
    end

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Judgement: a press while armed always wins over the closing step
    always_comb begin
        hit_next  = 1'b0;
        miss_next = 1'b0;
        lose      = 1'b0;
        if (state == ARMED) begin
            hit_next  = press;
            miss_next = step_tick && !press;
            lose      = step_tick && !press;
        end else if (state != OVER) begin
            miss_next = press;
`ifdef NOTE_JUDGE_STRICT_PRESS_EN
            lose      = press;
`else
            lose      = 1'b0;
`endif
        end
    end

    // FSM next state: losing the last life ends the game before any new note is armed
    always_comb begin
        state_next = state;
        if (state != OVER) begin
            if (lose && lives == 2'd1) state_next = OVER;
            else if (step_tick)        state_next = note_bit ? ARMED : IDLE;
            else if (hit_next)         state_next = DONE;
        end
    end

    // Saturating score, combo and life arithmetic
    always_comb begin
        score_sum  = {1'b0, score} + ((combo >= 4'd8) ? 9'd2 : 9'd1);
        score_next = hit_next ? (score_sum[8] ? 8'hFF : score_sum[7:0]) : score;
        combo_next = hit_next ? ((combo == 4'd15) ? combo : combo + 4'd1) : (miss_next ? 4'd0 : combo);
        lives_next = (lose && lives != 2'd0) ? lives - 2'd1 : lives;
    end

    // Registered counters and judgement pulses
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            score <= 8'd0;
            combo <= 4'd0;
            lives <= 2'd3;
            hit   <= 1'b0;
            miss  <= 1'b0;
        end else begin
            score <= score_next;
            combo <= combo_next;
            lives <= lives_next;
            hit   <= hit_next;
            miss  <= miss_next;
        end
    end

    // FSM outputs
    always_comb begin
        note_active = (state == ARMED);
        game_over   = (state == OVER);
    end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed scenarios plus randomized play checked against an event-level game model.
module tb_note_judge;
    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  current_number = 4'd0;
    logic [10:0] pattern = 11'd0;
    logic        key_press = 1'b0;
    logic [7:0]  score;
    logic [3:0]  combo;
    logic [1:0]  lives;
    logic        note_active, hit, miss, game_over;

    int checks = 0;
    int failures = 0;

`ifdef NOTE_JUDGE_STRICT_PRESS_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    note_judge dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .current_number(current_number),
        .pattern(pattern), .key_press(key_press), .score(score), .combo(combo),
        .lives(lives), .note_active(note_active), .hit(hit), .miss(miss),
        .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Game model: pending note, game-over flag, counters, and the key levels seen at recent edges
    int m_prev, m_score, m_combo, m_lives;
    bit m_pending, m_over, m_hit, m_miss;
    bit k0, k1, k2;

    task automatic model_step();
        bit tick, prs, lose;
        if (reset) begin
            m_prev = 15; k0 = 0; k1 = 0; k2 = 0;
            m_pending = 0; m_over = 0; m_score = 0; m_combo = 0; m_lives = 3;
            m_hit = 0; m_miss = 0;
            return;
        end
        tick = (int'(current_number) != m_prev) && (current_number <= 4'd10);
        prs = k1 && !k2;
        m_hit = 0; m_miss = 0; lose = 0;
        if (!m_over) begin
            if (m_pending && prs) m_hit = 1;
            else if (m_pending && tick) begin m_miss = 1; lose = 1; end
            else if (prs) begin m_miss = 1; lose = STRICT; end
            if (m_hit) m_pending = 0;
            if (tick) m_pending = pattern[current_number];
            if (m_hit) begin
                m_score = m_score + ((m_combo >= 8) ? 2 : 1);
                if (m_score > 255) m_score = 255;
                if (m_combo < 15) m_combo = m_combo + 1;
            end
            if (m_miss) m_combo = 0;
            if (lose) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) begin m_over = 1; m_pending = 0; end
            end
        end
        m_prev = int'(current_number);
        k2 = k1; k1 = k0; k0 = key_press;
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        key_press = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pattern = 11'h7FF;
        current_number = 4'd0;
        cycle();
        reset_dut();
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (combo !== 4'd0) begin failures++; $display("FAIL reset_combo got=%0d exp=0", combo); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++; if ({note_active, hit, miss, game_over} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {note_active, hit, miss, game_over}); end
    endtask

    task automatic test_single_miss();
        reset_dut();
        pattern = 11'h001;
        current_number = 4'd0;
        cycle();
        checks++; if (note_active !== 1'b1) begin failures++; $display("FAIL miss_armed got=%b exp=1", note_active); end
        current_number = 4'd1;
        cycle();
        checks++; if (miss !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL miss_pulse got hit=%b miss=%b exp hit=0 miss=1", hit, miss); end
        checks++; if (lives !== 2'd2) begin failures++; $display("FAIL miss_lives got=%0d exp=2", lives); end
        checks++; if (combo !== 4'd0 || note_active !== 1'b0) begin failures++; $display("FAIL miss_after got combo=%0d active=%b exp 0 0", combo, note_active); end
        cycle();
        checks++; if (miss !== 1'b0) begin failures++; $display("FAIL miss_one_cycle got=%b exp=0", miss); end
    endtask

    task automatic test_all_hits();
        int nh = 0;
        reset_dut();
        pattern = 11'h7FF;
        for (int s = 0; s < 10; s++) begin
            current_number = 4'(s);
            cycle(); nh += int'(hit);
            key_press = 1'b1;
            repeat (3) begin cycle(); nh += int'(hit); end
            key_press = 1'b0;
            cycle(); nh += int'(hit);
        end
        checks++; if (nh !== 10) begin failures++; $display("FAIL hits_count got=%0d exp=10", nh); end
        checks++; if (combo !== 4'd10) begin failures++; $display("FAIL hits_combo got=%0d exp=10", combo); end
        checks++; if (score !== 8'd12) begin failures++; $display("FAIL hits_score got=%0d exp=12", score); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL hits_lives got=%0d exp=3", lives); end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        pattern = 11'h003;
        current_number = 4'd0;
        cycle();
        key_press = 1'b1;
        cycle();
        cycle();
        current_number = 4'd1;
        cycle();
        key_press = 1'b0;
        checks++; if (hit !== 1'b1 || miss !== 1'b0) begin failures++; $display("FAIL simul_pulse got hit=%b miss=%b exp hit=1 miss=0", hit, miss); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL simul_lives got=%0d exp=3", lives); end
        checks++; if (note_active !== 1'b1) begin failures++; $display("FAIL simul_rearm got=%b exp=1", note_active); end
        checks++; if (score !== 8'd1 || combo !== 4'd1) begin failures++; $display("FAIL simul_score got score=%0d combo=%0d exp 1 1", score, combo); end
    endtask

    task automatic test_game_over();
        reset_dut();
        pattern = 11'h7FF;
        current_number = 4'd0;
        cycle();
        for (int s = 1; s <= 3; s++) begin
            current_number = 4'(s);
            cycle();
            checks++; if (lives !== 2'(3 - s)) begin failures++; $display("FAIL over_lives step=%0d got=%0d exp=%0d", s, lives, 3 - s); end
        end
        checks++; if (game_over !== 1'b1 || miss !== 1'b1) begin failures++; $display("FAIL over_enter got over=%b miss=%b exp 1 1", game_over, miss); end
        for (int n = 0; n < 8; n++) begin
            current_number = 4'(n + 4);
            key_press = (n % 4) < 2;
            cycle();
            checks++; if ({hit, miss} !== 2'b00 || lives !== 2'd0 || score !== 8'd0) begin failures++; $display("FAIL over_frozen n=%0d got hit=%b miss=%b lives=%0d score=%0d", n, hit, miss, lives, score); end
        end
        reset_dut();
        checks++; if (lives !== 2'd3 || game_over !== 1'b0) begin failures++; $display("FAIL over_reset got lives=%0d over=%b exp 3 0", lives, game_over); end
    endtask

    task automatic test_spurious_press();
        reset_dut();
        pattern = 11'h000;
        current_number = 4'd0;
        cycle();
        key_press = 1'b1;
        repeat (3) cycle();
        checks++; if (miss !== 1'b1 || combo !== 4'd0) begin failures++; $display("FAIL idle_press got miss=%b combo=%0d exp 1 0", miss, combo); end
        checks++; if (lives !== (STRICT ? 2'd2 : 2'd3)) begin failures++; $display("FAIL idle_lives got=%0d exp=%0d", lives, STRICT ? 2 : 3); end
        key_press = 1'b0;
        pattern = 11'h002;
        current_number = 4'd1;
        cycle();
        key_press = 1'b1;
        repeat (3) cycle();
        key_press = 1'b0;
        checks++; if (hit !== 1'b1 || combo !== 4'd1) begin failures++; $display("FAIL done_prehit got hit=%b combo=%0d exp 1 1", hit, combo); end
        cycle();
        cycle();
        key_press = 1'b1;
        repeat (3) cycle();
        key_press = 1'b0;
        checks++; if (miss !== 1'b1 || combo !== 4'd0) begin failures++; $display("FAIL done_press got miss=%b combo=%0d exp 1 0", miss, combo); end
        checks++; if (lives !== (STRICT ? 2'd1 : 2'd3)) begin failures++; $display("FAIL done_lives got=%0d exp=%0d", lives, STRICT ? 1 : 3); end
    endtask

    task automatic test_illegal_step();
        reset_dut();
        pattern = 11'h7FF;
        current_number = 4'd12;
        cycle();
        checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL illegal_idle got=%b exp=0", note_active); end
        current_number = 4'd5;
        cycle();
        current_number = 4'd13;
        cycle();
        checks++; if (note_active !== 1'b1 || miss !== 1'b0 || lives !== 2'd3) begin failures++; $display("FAIL illegal_hold got active=%b miss=%b lives=%0d exp 1 0 3", note_active, miss, lives); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) current_number = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) key_press = ~key_press;
            pattern = 11'($urandom);
            cycle();
            checks++; if (score !== 8'(m_score)) begin failures++; $display("FAIL rnd_score i=%0d got=%0d exp=%0d", i, score, m_score); end
            checks++; if (combo !== 4'(m_combo)) begin failures++; $display("FAIL rnd_combo i=%0d got=%0d exp=%0d", i, combo, m_combo); end
            checks++; if (lives !== 2'(m_lives)) begin failures++; $display("FAIL rnd_lives i=%0d got=%0d exp=%0d", i, lives, m_lives); end
            checks++; if (hit !== m_hit || miss !== m_miss) begin failures++; $display("FAIL rnd_pulse i=%0d got hit=%b miss=%b exp hit=%b miss=%b", i, hit, miss, m_hit, m_miss); end
            checks++; if (note_active !== (m_pending && !m_over)) begin failures++; $display("FAIL rnd_active i=%0d got=%b exp=%b", i, note_active, m_pending && !m_over); end
            checks++; if (game_over !== m_over) begin failures++; $display("FAIL rnd_over i=%0d got=%b exp=%b", i, game_over, m_over); end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_all_hits();
        test_simultaneous();
        test_game_over();
        test_spurious_press();
        test_illegal_step();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
